fpu_axis_issuer: RTL and testbench

- Initiator side of the AXI-stream handshake used by the single-precision add/sub IP.
- Accepts one FP request at a time from the Mini-MIPS execute stage.
- Add/sub requests are issued to the IP over three input channels (a, b, op), and the block waits for the result beat.
- Compare ops and MOV are resolved locally.
- One response per request is returned over a valid/ready port; busy stalls the core.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fp_cmp_local.sv | 35 +++
 rtl/fpu_axis_issuer.sv | 185 ++++++++++++++++++
 tb/tb_fpu_axis_issuer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared opcodes, IP operation codes and FSM state encoding for the FP
// request issuer.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_EQ  = 3'd2;
  localparam logic [2:0] OP_LT  = 3'd3;
  localparam logic [2:0] OP_GT  = 3'd4;
  localparam logic [2:0] OP_LE  = 3'd5;
  localparam logic [2:0] OP_GE  = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  localparam logic [7:0] IP_OP_ADD = 8'h00;
  localparam logic [7:0] IP_OP_SUB = 8'h01;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

endpackage

// File: rtl/fp_cmp_local.sv
// Combinational IEEE-754 single compare: any NaN makes all flags 0,
// +0 equals -0, otherwise sign-magnitude ordering.
module fp_cmp_local #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              eq_o,
  output logic              lt_o,
  output logic              gt_o
);

  logic a_nan, b_nan, both_zero, sa, sb, mag_lt, mag_eq, raw_lt, raw_eq;

  assign a_nan     = (a_i[DATA_W-2 -: 8] == 8'hFF) && (a_i[DATA_W-10:0] != '0);
  assign b_nan     = (b_i[DATA_W-2 -: 8] == 8'hFF) && (b_i[DATA_W-10:0] != '0);
  assign both_zero = (a_i[DATA_W-2:0] == '0) && (b_i[DATA_W-2:0] == '0);
  assign sa        = a_i[DATA_W-1];
  assign sb        = b_i[DATA_W-1];
  assign mag_lt    = a_i[DATA_W-2:0] < b_i[DATA_W-2:0];
  assign mag_eq    = a_i[DATA_W-2:0] == b_i[DATA_W-2:0];

  always_comb begin
    raw_eq = both_zero || (a_i == b_i);
    if (both_zero)     raw_lt = 1'b0;
    else if (sa != sb) raw_lt = sa;
    else if (!sa)      raw_lt = mag_lt;
    else               raw_lt = !mag_lt && !mag_eq;
  end

  assign eq_o = !(a_nan || b_nan) && raw_eq;
  assign lt_o = !(a_nan || b_nan) && raw_lt;
  assign gt_o = !(a_nan || b_nan) && !raw_lt && !raw_eq;

endmodule

// File: rtl/fpu_axis_issuer.sv
// Issues add/sub to the AXI-stream FP IP, resolves compares/MOV locally,
// returns one response per request with timeout abort.
module fpu_axis_issuer
  import fpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_rd,
  output logic              rsp_err,
  output logic              busy,
  output logic              m_axis_a_tvalid,
  input  logic              m_axis_a_tready,
  output logic [DATA_W-1:0] m_axis_a_tdata,
  output logic              m_axis_b_tvalid,
  input  logic              m_axis_b_tready,
  output logic [DATA_W-1:0] m_axis_b_tdata,
  output logic              m_axis_op_tvalid,
  input  logic              m_axis_op_tready,
  output logic [7:0]        m_axis_op_tdata,
  input  logic              s_axis_res_tvalid,
  output logic              s_axis_res_tready,
  input  logic [DATA_W-1:0] s_axis_res_tdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d, local_res;
  logic [7:0]        ipop_q, ipop_d;
  logic [TAG_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic err_q, err_d, drop_q, drop_d, rdy_q, rdy_d;
  logic a_sent_q, a_sent_d, b_sent_q, b_sent_d, op_sent_q, op_sent_d;
  logic eq, lt, gt, flag, req_hs, a_hs, b_hs, op_hs, res_hs, timeout;

  fp_cmp_local #(.DATA_W(DATA_W)) u_cmp (
    .a_i(req_a), .b_i(req_b), .eq_o(eq), .lt_o(lt), .gt_o(gt)
  );

  always_comb begin
    flag = 1'b0;
    case (req_op)
      OP_EQ:   flag = eq;
      OP_LT:   flag = lt;
      OP_GT:   flag = gt;
      OP_LE:   flag = lt | eq;
      OP_GE:   flag = gt | eq;
      default: flag = 1'b0;
    endcase
    local_res = (req_op == OP_MOV) ? req_a : {{(DATA_W-1){1'b0}}, flag};
  end

  assign req_ready         = rdy_q;
  assign busy              = (state_q != IDLE);
  assign rsp_valid         = (state_q == RESP);
  assign rsp_data          = data_q;
  assign rsp_rd            = rd_q;
  assign rsp_err           = err_q;
  assign m_axis_a_tvalid   = (state_q == SEND) && !a_sent_q;
  assign m_axis_b_tvalid   = (state_q == SEND) && !b_sent_q;
  assign m_axis_op_tvalid  = (state_q == SEND) && !op_sent_q;
  assign m_axis_a_tdata    = a_q;
  assign m_axis_b_tdata    = b_q;
  assign m_axis_op_tdata   = ipop_q;
  // A result owed from an aborted op is still drained while idle or responding.
  assign s_axis_res_tready = (state_q == WAIT) || drop_q;

  assign req_hs  = req_valid && rdy_q;
  assign a_hs    = m_axis_a_tvalid && m_axis_a_tready;
  assign b_hs    = m_axis_b_tvalid && m_axis_b_tready;
  assign op_hs   = m_axis_op_tvalid && m_axis_op_tready;
  assign res_hs  = s_axis_res_tvalid && s_axis_res_tready;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    ipop_d    = ipop_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    a_sent_d  = a_sent_q;
    b_sent_d  = b_sent_q;
    op_sent_d = op_sent_q;
    drop_d    = drop_q;
    if (drop_q && res_hs) drop_d = 1'b0;
    case (state_q)
      IDLE: if (req_hs) begin
        a_d  = req_a;
        b_d  = req_b;
        rd_d = req_rd;
        if (req_op == OP_ADD || req_op == OP_SUB) begin
          ipop_d    = (req_op == OP_SUB) ? IP_OP_SUB : IP_OP_ADD;
          cnt_d     = '0;
          a_sent_d  = 1'b0;
          b_sent_d  = 1'b0;
          op_sent_d = 1'b0;
          state_d   = SEND;
        end else begin
          data_d  = local_res;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      SEND: begin
        a_sent_d  = a_sent_q | a_hs;
        b_sent_d  = b_sent_q | b_hs;
        op_sent_d = op_sent_q | op_hs;
        if (timeout) begin
          data_d  = DATA_W'(QNAN);
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (a_sent_d && b_sent_d && op_sent_d) state_d = WAIT;
        end
      end
      WAIT: begin
        if (res_hs && !drop_q) begin
          data_d  = s_axis_res_tdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout) begin
          data_d  = DATA_W'(QNAN);
          err_d   = 1'b1;
          drop_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      ipop_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      a_sent_q  <= 1'b0;
      b_sent_q  <= 1'b0;
      op_sent_q <= 1'b0;
      drop_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      ipop_q    <= ipop_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      a_sent_q  <= a_sent_d;
      b_sent_q  <= b_sent_d;
      op_sent_q <= op_sent_d;
      drop_q    <= drop_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_fpu_axis_issuer.sv
// Directed bench for fpu_axis_issuer; the bench plays both the core and the IP.
module tb_fpu_axis_issuer;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err, busy;
  logic        a_tvalid, a_tready = 1'b1, b_tvalid, b_tready = 1'b1;
  logic        op_tvalid, op_tready = 1'b1;
  logic [31:0] a_tdata, b_tdata;
  logic [7:0]  op_tdata;
  logic        res_tvalid = 1'b0, res_tready;
  logic [31:0] res_tdata = '0;

  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  fpu_axis_issuer #(.DATA_W(32), .TAG_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .busy(busy),
    .m_axis_a_tvalid(a_tvalid), .m_axis_a_tready(a_tready), .m_axis_a_tdata(a_tdata),
    .m_axis_b_tvalid(b_tvalid), .m_axis_b_tready(b_tready), .m_axis_b_tdata(b_tdata),
    .m_axis_op_tvalid(op_tvalid), .m_axis_op_tready(op_tready), .m_axis_op_tdata(op_tdata),
    .s_axis_res_tvalid(res_tvalid), .s_axis_res_tready(res_tready),
    .s_axis_res_tdata(res_tdata)
  );

  // Inputs change only on the falling edge, right after that edge's samples.
  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, b, input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({req_ready, rsp_valid, busy, a_tvalid, b_tvalid, op_tvalid, res_tready, rsp_err} !== 8'h00
        || rsp_data !== 32'h0 || rsp_rd !== 5'h0) begin
      fails++;
      $display("FAIL reset_outputs got ctl=%b data=%h rd=%h exp all zero",
               {req_ready, rsp_valid, busy, a_tvalid, b_tvalid, op_tvalid, res_tready, rsp_err},
               rsp_data, rsp_rd);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_add;
    int n;
    logic busy_ok;
    drive_req(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
    checks++;
    if ({a_tvalid, b_tvalid, op_tvalid} !== 3'b111 || a_tdata !== 32'h3F80_0000 ||
        b_tdata !== 32'h4000_0000 || op_tdata !== 8'h00 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL add_send got v=%b a=%h b=%h op=%h rdy=%b exp v=111 a=3f800000 b=40000000 op=00 rdy=0",
               {a_tvalid, b_tvalid, op_tvalid}, a_tdata, b_tdata, op_tdata, req_ready);
    end
    @(negedge clk);
    checks++;
    if (res_tready !== 1'b1 || {a_tvalid, b_tvalid, op_tvalid} !== 3'b000) begin
      fails++;
      $display("FAIL add_wait got res_tready=%b v=%b exp 1 000", res_tready, {a_tvalid, b_tvalid, op_tvalid});
    end
    busy_ok = busy;
    @(negedge clk);
    busy_ok &= busy;
    @(negedge clk);
    busy_ok &= busy;
    res_tvalid = 1'b1; res_tdata = 32'h4040_0000;
    @(negedge clk);
    res_tvalid = 1'b0;
    wait_rsp(20, n);
    checks++;
    if (n !== 0 || rsp_data !== 32'h4040_0000 || rsp_err !== 1'b0 || rsp_rd !== 5'd5 ||
        !busy_ok || busy !== 1'b1) begin
      fails++;
      $display("FAIL add_rsp got late=%0d data=%h err=%b rd=%0d busy_ok=%b exp 0 40400000 0 5 1",
               n, rsp_data, rsp_err, rsp_rd, busy_ok);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL add_done got v=%b rdy=%b busy=%b exp 0 1 0", rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_sub_backpressure;
    int n;
    logic held_ok;
    a_tready = 1'b0;
    drive_req(3'd1, 32'h4000_0000, 32'h3F80_0000, 5'd12);
    checks++;
    if ({a_tvalid, b_tvalid, op_tvalid} !== 3'b111 || op_tdata !== 8'h01) begin
      fails++;
      $display("FAIL sub_first got v=%b op=%h exp 111 01", {a_tvalid, b_tvalid, op_tvalid}, op_tdata);
    end
    held_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      held_ok &= (a_tvalid === 1'b1) && (b_tvalid === 1'b0) && (op_tvalid === 1'b0) &&
                 (a_tdata === 32'h4000_0000) && (res_tready === 1'b0);
    end
    checks++;
    if (!held_ok) begin
      fails++;
      $display("FAIL sub_a_held got ok=%b exp a held alone with stable data", held_ok);
    end
    a_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_tvalid !== 1'b0 || res_tready !== 1'b1) begin
      fails++;
      $display("FAIL sub_to_wait got a_tvalid=%b res_tready=%b exp 0 1", a_tvalid, res_tready);
    end
    res_tvalid = 1'b1; res_tdata = 32'h3F80_0000;
    @(negedge clk);
    res_tvalid = 1'b0;
    wait_rsp(20, n);
    checks++;
    if (n !== 0 || rsp_data !== 32'h3F80_0000 || rsp_rd !== 5'd12 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL sub_rsp got late=%0d data=%h rd=%0d err=%b exp 0 3f800000 12 0", n, rsp_data, rsp_rd, rsp_err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_local;
    logic [2:0]  ops [6] = '{3'd3, 3'd6, 3'd2, 3'd7, 3'd4, 3'd5};
    logic [31:0] as  [6] = '{32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'hC123_4567, 32'hC000_0000, 32'hBF80_0000};
    logic [31:0] bs  [6] = '{32'h4000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h1111_1111, 32'hBF80_0000, 32'h3F80_0000};
    logic [31:0] exp [6] = '{32'h1, 32'h1, 32'h0, 32'hC123_4567, 32'h0, 32'h1};
    for (int i = 0; i < 6; i++) begin
      drive_req(ops[i], as[i], bs[i], 5'(i + 20));
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_rd !== 5'(i + 20) || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL local_%0d got v=%b data=%h rd=%0d err=%b exp 1 %h %0d 0",
                 i, rsp_valid, rsp_data, rsp_rd, rsp_err, exp[i], i + 20);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_timeout;
    int n;
    logic quiet;
    drive_req(3'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd3);
    n = 1;
    wait_rsp(40, n);
    checks++;
    if (n !== 16 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL timeout_latency got extra_cycles=%0d v=%b exp 16 1", n, rsp_valid);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'h7FC0_0000 || res_tready !== 1'b1 ||
        {a_tvalid, b_tvalid, op_tvalid} !== 3'b000) begin
      fails++;
      $display("FAIL timeout_rsp got err=%b data=%h res_tready=%b exp 1 7fc00000 1", rsp_err, rsp_data, res_tready);
    end
    res_tvalid = 1'b1; res_tdata = 32'h1234_5678;
    @(negedge clk);
    res_tvalid = 1'b0;
    checks++;
    if (res_tready !== 1'b0 || rsp_data !== 32'h7FC0_0000 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL timeout_drop got res_tready=%b data=%h v=%b exp 0 7fc00000 1", res_tready, rsp_data, rsp_valid);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      quiet &= (rsp_valid === 1'b0);
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin
      fails++;
      $display("FAIL timeout_no_extra got extra rsp_valid exp none");
    end
    drive_req(3'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd4);
    @(negedge clk);
    res_tvalid = 1'b1; res_tdata = 32'h4000_0000;
    @(negedge clk);
    res_tvalid = 1'b0;
    wait_rsp(20, n);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h4000_0000 || rsp_err !== 1'b0 || rsp_rd !== 5'd4) begin
      fails++;
      $display("FAIL timeout_recover got v=%b data=%h err=%b rd=%0d exp 1 40000000 0 4", rsp_valid, rsp_data, rsp_err, rsp_rd);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_stall;
    logic stable;
    drive_req(3'd7, 32'hDEAD_BEEF, 32'h0, 5'd9);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stable &= (rsp_valid === 1'b1) && (rsp_data === 32'hDEAD_BEEF) && (rsp_rd === 5'd9) &&
                (req_ready === 1'b0) && (busy === 1'b1);
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      fails++;
      $display("FAIL stall_hold got unstable response exp held v=1 data=deadbeef rd=9 rdy=0");
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_release got v=%b rdy=%b busy=%b exp 0 1 0", rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic quiet;
    drive_req(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd7);
    @(negedge clk);
    checks++;
    if (res_tready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre got res_tready=%b busy=%b exp 1 1", res_tready, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, a_tvalid, b_tvalid, op_tvalid, res_tready} !== 7'h00 ||
        rsp_data !== 32'h0 || a_tdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_async got ctl=%b data=%h a=%h exp all zero",
               {req_ready, rsp_valid, busy, a_tvalid, b_tvalid, op_tvalid, res_tready}, rsp_data, a_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      quiet &= (rsp_valid === 1'b0) && (busy === 1'b0);
    end
    checks++;
    if (!quiet || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_after got quiet=%b rdy=%b exp 1 1", quiet, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_backpressure();
    test_local();
    test_timeout();
    test_rsp_stall();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish got timeout exp completion");
    $fatal(1);
  end

endmodule
